// File: rtl/uart_slave_rx_frontend.sv
// Slave-side serial receive front end.
// Deserialises the control frame (start, slave ID, rdWr, burst, address), filters it
// by slave ID, publishes the decoded request, and for writes deserialises wD words
// into memory write strobes with burst address auto-increment.
module uart_slave_rx_frontend #(
   parameter int unsigned  DATA_WIDTH    = 8,
   parameter int unsigned  MEMORY_DEPTH  = 4096,
   parameter logic [1:0]   SLAVEID       = 2'd1,
   localparam int unsigned ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     control,
   input  logic                     wD,
   input  logic                     valid,
   input  logic                     last,
   output logic                     ready,
   output logic                     cfg_valid,
   output logic                     cfg_rdWr,
   output logic                     cfg_burst,
   output logic [ADDRESS_WIDTH-1:0] cfg_address,
   output logic                     rd_req,
   output logic                     mem_we,
   output logic [ADDRESS_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0]    mem_wdata,
   output logic                     busy
);

   // Header after the start bits: ID[1:0], rdWr, burst, address.
   localparam int unsigned HDR_W = ADDRESS_WIDTH + 4;
   localparam int unsigned HCW   = $clog2(HDR_W + 1);
   localparam int unsigned BCW   = $clog2(DATA_WIDTH + 1);

   localparam int unsigned ID_HI    = HDR_W - 1;
   localparam int unsigned ID_LO    = HDR_W - 2;
   localparam int unsigned RDWR_BIT = ADDRESS_WIDTH + 1;
   localparam int unsigned BURST_BIT = ADDRESS_WIDTH;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StHeader,
      StDecode,
      StWrite,
      StDone
   } state_e;

   state_e                   state_q, state_d;
   logic [1:0]               start_cnt_q, start_cnt_d;
   logic [HDR_W-1:0]         hdr_q, hdr_d;
   logic [HCW-1:0]           hdr_cnt_q, hdr_cnt_d;
   logic [DATA_WIDTH-1:0]    word_q, word_d;
   logic [BCW-1:0]           bit_cnt_q, bit_cnt_d;
   logic [ADDRESS_WIDTH-1:0] addr_cnt_q, addr_cnt_d;
   logic                     cfg_valid_q, cfg_valid_d;
   logic                     cfg_rdwr_q, cfg_rdwr_d;
   logic                     cfg_burst_q, cfg_burst_d;
   logic [ADDRESS_WIDTH-1:0] cfg_address_q, cfg_address_d;
   logic                     rd_req_q, rd_req_d;
   logic                     mem_we_q, mem_we_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic                     ready_q, ready_d;
   logic                     busy_q, busy_d;

   logic [HDR_W-1:0]      hdr_next;
   logic [DATA_WIDTH-1:0] word_next;
   logic                  id_match_next;
   logic                  id_match_q;

   assign hdr_next      = {hdr_q[HDR_W-2:0], control};
   assign word_next     = {word_q[DATA_WIDTH-2:0], wD};
   assign id_match_next = (hdr_next[ID_HI:ID_LO] == SLAVEID);
   assign id_match_q    = (hdr_q[ID_HI:ID_LO] == SLAVEID);

   // State and datapath registers; reset clears everything and parks in idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= StIdle;
         start_cnt_q   <= '0;
         hdr_q         <= '0;
         hdr_cnt_q     <= '0;
         word_q        <= '0;
         bit_cnt_q     <= '0;
         addr_cnt_q    <= '0;
         cfg_valid_q   <= 1'b0;
         cfg_rdwr_q    <= 1'b0;
         cfg_burst_q   <= 1'b0;
         cfg_address_q <= '0;
         rd_req_q      <= 1'b0;
         mem_we_q      <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
         ready_q       <= 1'b1;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         start_cnt_q   <= start_cnt_d;
         hdr_q         <= hdr_d;
         hdr_cnt_q     <= hdr_cnt_d;
         word_q        <= word_d;
         bit_cnt_q     <= bit_cnt_d;
         addr_cnt_q    <= addr_cnt_d;
         cfg_valid_q   <= cfg_valid_d;
         cfg_rdwr_q    <= cfg_rdwr_d;
         cfg_burst_q   <= cfg_burst_d;
         cfg_address_q <= cfg_address_d;
         rd_req_q      <= rd_req_d;
         mem_we_q      <= mem_we_d;
         mem_addr_q    <= mem_addr_d;
         mem_wdata_q   <= mem_wdata_d;
         ready_q       <= ready_d;
         busy_q        <= busy_d;
      end
   end

   // Next-state and registered-output logic; pulses default low, buses hold.
   always_comb begin
      state_d       = state_q;
      start_cnt_d   = start_cnt_q;
      hdr_d         = hdr_q;
      hdr_cnt_d     = hdr_cnt_q;
      word_d        = word_q;
      bit_cnt_d     = bit_cnt_q;
      addr_cnt_d    = addr_cnt_q;
      cfg_valid_d   = 1'b0;
      cfg_rdwr_d    = cfg_rdwr_q;
      cfg_burst_d   = cfg_burst_q;
      cfg_address_d = cfg_address_q;
      rd_req_d      = 1'b0;
      mem_we_d      = 1'b0;
      mem_addr_d    = mem_addr_q;
      mem_wdata_d   = mem_wdata_q;

      unique case (state_q)
         StIdle: begin
            if (control) begin
               state_d     = StStart;
               start_cnt_d = 2'd1;
            end
         end

         StStart: begin
            if (control) begin
               if (start_cnt_q == 2'd2) begin
                  // Third consecutive start bit: frame accepted.
                  state_d     = StHeader;
                  start_cnt_d = '0;
                  hdr_cnt_d   = '0;
               end else begin
                  start_cnt_d = start_cnt_q + 1'b1;
               end
            end else begin
               // Short run of ones is treated as line noise.
               state_d     = StIdle;
               start_cnt_d = '0;
            end
         end

         StHeader: begin
            hdr_d = hdr_next;
            if (hdr_cnt_q == HCW'(HDR_W - 1)) begin
               state_d   = StDecode;
               hdr_cnt_d = '0;
               // Decode results are registered here so they appear in the decode cycle.
               if (id_match_next) begin
                  cfg_valid_d   = 1'b1;
                  cfg_rdwr_d    = hdr_next[RDWR_BIT];
                  cfg_burst_d   = hdr_next[BURST_BIT];
                  cfg_address_d = hdr_next[ADDRESS_WIDTH-1:0];
                  rd_req_d      = ~hdr_next[RDWR_BIT];
                  addr_cnt_d    = hdr_next[ADDRESS_WIDTH-1:0];
               end
            end else begin
               hdr_cnt_d = hdr_cnt_q + 1'b1;
            end
         end

         StDecode: begin
            if (id_match_q && hdr_q[RDWR_BIT]) begin
               state_d   = StWrite;
               word_d    = '0;
               bit_cnt_d = '0;
            end else begin
               state_d = StDone;
            end
         end

         StWrite: begin
            if (valid) begin
               word_d = word_next;
               if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                  bit_cnt_d   = '0;
                  mem_we_d    = 1'b1;
                  mem_addr_d  = addr_cnt_q;
                  mem_wdata_d = word_next;
                  if (!cfg_burst_q || last) begin
                     state_d = StDone;
                  end else if (addr_cnt_q == ADDRESS_WIDTH'(MEMORY_DEPTH - 1)) begin
                     addr_cnt_d = '0;
                  end else begin
                     addr_cnt_d = addr_cnt_q + 1'b1;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end

         StDone: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      ready_d = (state_d == StIdle) || (state_d == StWrite);
      busy_d  = (state_d != StIdle);
   end

   assign ready       = ready_q;
   assign busy        = busy_q;
   assign cfg_valid   = cfg_valid_q;
   assign cfg_rdWr    = cfg_rdwr_q;
   assign cfg_burst   = cfg_burst_q;
   assign cfg_address = cfg_address_q;
   assign rd_req      = rd_req_q;
   assign mem_we      = mem_we_q;
   assign mem_addr    = mem_addr_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_uart_slave_rx_frontend.sv
// Directed self-checking bench for uart_slave_rx_frontend.
module tb_uart_slave_rx_frontend;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 12;

   logic          clk;
   logic          rst;
   logic          control;
   logic          wD;
   logic          valid;
   logic          last;
   logic          ready;
   logic          cfg_valid;
   logic          cfg_rdWr;
   logic          cfg_burst;
   logic [AW-1:0] cfg_address;
   logic          rd_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;

   int checks = 0;
   int errors = 0;
   int we_cnt = 0;
   int cv_cnt = 0;

   uart_slave_rx_frontend #(
      .DATA_WIDTH  (DW),
      .MEMORY_DEPTH(4096),
      .SLAVEID     (2'd1)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .control    (control),
      .wD         (wD),
      .valid      (valid),
      .last       (last),
      .ready      (ready),
      .cfg_valid  (cfg_valid),
      .cfg_rdWr   (cfg_rdWr),
      .cfg_burst  (cfg_burst),
      .cfg_address(cfg_address),
      .rd_req     (rd_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled on the inactive edge.
   always @(negedge clk) begin
      if (mem_we === 1'b1) we_cnt++;
      if (cfg_valid === 1'b1) cv_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [18:0] f);
      for (int i = 18; i >= 0; i--) begin
         control = f[i];
         tick();
      end
      control = 1'b0;
   endtask

   // Sends one word MSB first; optionally drops valid for 3 cycles after pause_at bits.
   task automatic send_word(input logic [DW-1:0] w, input logic lst, input int pause_at);
      for (int i = DW - 1; i >= 0; i--) begin
         if ((DW - 1 - i) == pause_at) begin
            for (int p = 0; p < 3; p++) begin
               valid = 1'b0;
               wD    = ~wD;
               tick();
            end
         end
         valid = 1'b1;
         wD    = w[i];
         last  = lst;
         tick();
      end
      valid = 1'b0;
      last  = 1'b0;
      wD    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; control = 1'b1; wD = 1'b0; valid = 1'b0; last = 1'b0;
      tick();
      tick();
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b want 0", mem_we); end
      checks++; if (cfg_address !== 12'd0) begin errors++; $display("FAIL reset_cfg_address got %0d want 0", cfg_address); end
      rst = 1'b0; control = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_no_frame got busy %b want 0", busy); end
   endtask

   task automatic test_burst_write();
      int we0;
      we0 = we_cnt;
      send_frame(19'b111_01_1_1_000000000011);
      checks++; if (cfg_valid !== 1'b1) begin errors++; $display("FAIL bw_cfg_valid got %b want 1", cfg_valid); end
      checks++; if ({cfg_rdWr, cfg_burst} !== 2'b11) begin errors++; $display("FAIL bw_rdwr_burst got %b want 11", {cfg_rdWr, cfg_burst}); end
      checks++; if (cfg_address !== 12'd3) begin errors++; $display("FAIL bw_cfg_address got %0d want 3", cfg_address); end
      checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL bw_rd_req got %b want 0", rd_req); end
      tick();
      checks++; if (cfg_valid !== 1'b0) begin errors++; $display("FAIL bw_cfg_valid_pulse got %b want 0", cfg_valid); end
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL bw_ready_write got %b want 1", ready); end
      send_word(8'h0E, 1'b0, -1);
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd3, 8'h0E}) begin errors++; $display("FAIL bw_word0 got we %b addr %0d data %h want 1 3 0e", mem_we, mem_addr, mem_wdata); end
      send_word(8'h5A, 1'b0, -1);
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd4, 8'h5A}) begin errors++; $display("FAIL bw_word1 got we %b addr %0d data %h want 1 4 5a", mem_we, mem_addr, mem_wdata); end
      send_word(8'h11, 1'b1, -1);
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd5, 8'h11}) begin errors++; $display("FAIL bw_word2 got we %b addr %0d data %h want 1 5 11", mem_we, mem_addr, mem_wdata); end
      checks++; if ({ready, busy} !== 2'b01) begin errors++; $display("FAIL bw_done got ready/busy %b want 01", {ready, busy}); end
      tick();
      checks++; if ({ready, busy, mem_we} !== 3'b100) begin errors++; $display("FAIL bw_idle got ready/busy/we %b want 100", {ready, busy, mem_we}); end
      checks++; if (we_cnt - we0 !== 3) begin errors++; $display("FAIL bw_we_count got %0d want 3", we_cnt - we0); end
   endtask

   task automatic test_read_request();
      int we0;
      we0 = we_cnt;
      send_frame(19'b111_01_0_1_000000000101);
      checks++; if ({cfg_valid, rd_req} !== 2'b11) begin errors++; $display("FAIL rd_pulses got %b want 11", {cfg_valid, rd_req}); end
      checks++; if ({cfg_rdWr, cfg_address} !== {1'b0, 12'd5}) begin errors++; $display("FAIL rd_cfg got rdwr %b addr %0d want 0 5", cfg_rdWr, cfg_address); end
      tick();
      checks++; if ({cfg_valid, rd_req, ready, busy} !== 4'b0001) begin errors++; $display("FAIL rd_done got %b want 0001", {cfg_valid, rd_req, ready, busy}); end
      tick();
      tick();
      checks++; if ({ready, busy} !== 2'b10) begin errors++; $display("FAIL rd_idle got %b want 10", {ready, busy}); end
      checks++; if (we_cnt !== we0) begin errors++; $display("FAIL rd_no_we got %0d want %0d", we_cnt, we0); end
   endtask

   task automatic test_id_filter_glitch();
      int cv0;
      cv0 = cv_cnt;
      send_frame(19'b111_10_1_0_000000001111);
      tick();
      tick();
      tick();
      checks++; if (cv_cnt !== cv0) begin errors++; $display("FAIL id_no_cfg_valid got %0d want %0d", cv_cnt, cv0); end
      checks++; if ({cfg_rdWr, cfg_burst, cfg_address} !== {1'b0, 1'b1, 12'd5}) begin errors++; $display("FAIL id_cfg_held got %b %b %0d want 0 1 5", cfg_rdWr, cfg_burst, cfg_address); end
      checks++; if ({ready, busy} !== 2'b10) begin errors++; $display("FAIL id_idle got %b want 10", {ready, busy}); end
      control = 1'b1; tick();
      checks++; if ({ready, busy} !== 2'b01) begin errors++; $display("FAIL glitch_start got %b want 01", {ready, busy}); end
      tick();
      control = 1'b0; tick();
      checks++; if ({ready, busy} !== 2'b10) begin errors++; $display("FAIL glitch_reject got %b want 10", {ready, busy}); end
      for (int i = 0; i < 20; i++) tick();
      checks++; if ({cv_cnt, busy} !== {cv0, 1'b0}) begin errors++; $display("FAIL glitch_no_decode got cv %0d busy %b want %0d 0", cv_cnt, busy, cv0); end
   endtask

   task automatic test_wrap_pause();
      send_frame(19'b111_01_1_1_111111111111);
      checks++; if (cfg_address !== 12'hFFF) begin errors++; $display("FAIL wrap_cfg_address got %h want fff", cfg_address); end
      tick();
      send_word(8'hA5, 1'b0, 4);
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'hFFF, 8'hA5}) begin errors++; $display("FAIL wrap_word0 got we %b addr %h data %h want 1 fff a5", mem_we, mem_addr, mem_wdata); end
      send_word(8'h3C, 1'b1, -1);
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h000, 8'h3C}) begin errors++; $display("FAIL wrap_word1 got we %b addr %h data %h want 1 000 3c", mem_we, mem_addr, mem_wdata); end
      tick();
      tick();
   endtask

   task automatic test_nonburst_reset();
      int we0;
      we0 = we_cnt;
      send_frame(19'b111_01_1_0_000000000111);
      checks++; if ({cfg_valid, cfg_rdWr, cfg_burst} !== 3'b110) begin errors++; $display("FAIL nb_cfg got %b want 110", {cfg_valid, cfg_rdWr, cfg_burst}); end
      tick();
      send_word(8'h77, 1'b0, -1);
      checks++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'd7, 8'h77}) begin errors++; $display("FAIL nb_word got we %b addr %0d data %h want 1 7 77", mem_we, mem_addr, mem_wdata); end
      checks++; if ({ready, busy} !== 2'b01) begin errors++; $display("FAIL nb_done got %b want 01", {ready, busy}); end
      send_word(8'h88, 1'b0, -1);
      tick();
      tick();
      checks++; if (we_cnt - we0 !== 1) begin errors++; $display("FAIL nb_single_we got %0d want 1", we_cnt - we0); end

      we0 = we_cnt;
      send_frame(19'b111_01_1_1_000000001001);
      tick();
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; wD = 1'b1; tick();
      end
      valid = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if ({ready, busy, mem_we} !== 3'b100) begin errors++; $display("FAIL rst_state got %b want 100", {ready, busy, mem_we}); end
      checks++; if ({cfg_rdWr, cfg_burst, cfg_address, mem_addr} !== '0) begin errors++; $display("FAIL rst_cleared got %b %b %0d %0d want all 0", cfg_rdWr, cfg_burst, cfg_address, mem_addr); end
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; wD = 1'b0; tick();
      end
      valid = 1'b0;
      tick();
      tick();
      checks++; if ({we_cnt, busy} !== {we0, 1'b0}) begin errors++; $display("FAIL rst_no_we got we %0d busy %b want %0d 0", we_cnt, busy, we0); end
   endtask

   initial begin
      rst = 1'b1; control = 1'b0; wD = 1'b0; valid = 1'b0; last = 1'b0;
      test_reset();
      test_burst_write();
      test_read_request();
      test_id_filter_glitch();
      test_wrap_pause();
      test_nonburst_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
